// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART frame constants and transmitter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS_N = 8;
    localparam int STOP_BITS_N = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Bus-side write port and line status of the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;

    logic       we;
    logic [7:0] din;
    logic       full;
    logic       busy;
    logic       tx;

    modport master (output we, output din, input full, input busy, input tx);
    modport slave  (input we, input din, output full, output busy, output tx);

endinterface : uart_tx_if
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : Synchronous byte FIFO with registered full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_push,
    input  wire logic       i_pop,
    input  wire logic [7:0] i_din,
    output logic      [7:0] o_dout,
    output logic            o_full,
    output logic            o_empty
);

    localparam int                c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_full_cnt = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]     c_cnt_one  = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0]   c_ptr_one  = c_aw'(1);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [c_aw:0]   w_count_nxt;
    logic            r_full;
    logic            w_push_ok;
    logic            w_pop_ok;

    // Push is gated by the registered flag, so a same-edge pop cannot admit a write.
    assign w_push_ok = i_push & ~r_full;
    assign w_pop_ok  = i_pop & (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_full_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);

endmodule : uart_fifo
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter, LSB first, fed from an internal FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1000,
    parameter int DEPTH        = 4
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    uart_tx_if.slave   bus
);

    localparam logic [15:0] c_bit_last = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  c_idx_last = 3'(DATA_BITS_N - 1);

    uart_state_t r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_tx, w_tx_nxt;
    logic        w_pop;
    logic        w_bit_done;
    logic [7:0]  w_fifo_dout;
    logic        w_fifo_full;
    logic        w_fifo_empty;

    uart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.we),
        .i_pop   (w_pop),
        .i_din   (bus.din),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_bit_done = (r_cnt == c_bit_last);

    // The line level is derived from the current state and then registered,
    // so tx trails the state register by one clock.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = 1'b1;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = START_BIT;
                end
            end
            START_BIT: begin
                w_tx_nxt = 1'b0;
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DATA_BITS;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            DATA_BITS: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == c_idx_last) w_state_nxt = STOP_BIT;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            STOP_BIT: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_idx_nxt   = '0;
                        w_state_nxt = START_BIT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    assign bus.tx   = r_tx;
    assign bus.full = w_fifo_full;
    assign bus.busy = (r_state != IDLE) | ~w_fifo_empty;

endmodule : uart_tx
`default_nettype wire
